// File: rtl/product_accumulator.sv
// product_accumulator: sums N valid/ready products into a frame sum with a sticky overflow flag.
// Define ACC_SATURATE_EN to clamp at the maximum value instead of wrapping.
module product_accumulator #(
  parameter int N     = 8,
  parameter int ACC_W = 12
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       prod,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] sum,
  output logic             ovf,
  output logic [4:0]       cnt
);
  typedef enum logic {ACC, OUT} state_t;
  state_t           state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d, sum_q, sum_d, acc_nx;
  logic             sticky_q, sticky_d, ovf_q, ovf_d, carry, accept, last;
  logic [5:0]       cnt_q, cnt_d;
  logic [ACC_W:0]   ext;
  assign ext    = {1'b0, acc_q} + (ACC_W+1)'(prod);
  assign carry  = ext[ACC_W];
`ifdef ACC_SATURATE_EN
  assign acc_nx = carry ? '1 : ext[ACC_W-1:0];
`else
  assign acc_nx = ext[ACC_W-1:0];
`endif
  assign in_ready  = state_q == ACC && !clr;
  assign out_valid = state_q == OUT;
  assign accept    = in_valid && in_ready;
  assign last      = cnt_q == 6'(N-1);
  assign sum       = sum_q;
  assign ovf       = ovf_q;
  // Internal count is 6 bits so that N=32 can be reached; the port shows the low 5.
  assign cnt       = cnt_q[4:0];
  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    sticky_d = sticky_q;
    cnt_d    = cnt_q;
    sum_d    = sum_q;
    ovf_d    = ovf_q;
    if (clr || (state_q == OUT && out_ready)) begin
      state_d  = ACC;
      acc_d    = '0;
      sticky_d = 1'b0;
      cnt_d    = '0;
    end else if (accept) begin
      acc_d    = acc_nx;
      sticky_d = sticky_q | carry;
      cnt_d    = cnt_q + 6'd1;
      if (last) begin
        sum_d   = acc_nx;
        ovf_d   = sticky_q | carry;
        state_d = OUT;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ACC;
      acc_q    <= '0;
      sticky_q <= 1'b0;
      cnt_q    <= '0;
      sum_q    <= '0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      sticky_q <= sticky_d;
      cnt_q    <= cnt_d;
      sum_q    <= sum_d;
      ovf_q    <= ovf_d;
    end
  end
endmodule

// File: tb/tb_product_accumulator.sv
// tb_product_accumulator: directed checks of three product_accumulator configurations.
module tb_product_accumulator;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  logic a_clr = 0, a_iv = 0, a_ir, a_ov, a_or = 0, a_ovf;
  logic [7:0] a_prod = 0;
  logic [11:0] a_sum;
  logic [4:0] a_cnt;
  logic b_clr = 0, b_iv = 0, b_ir, b_ov, b_or = 0, b_ovf;
  logic [7:0] b_prod = 0;
  logic [7:0] b_sum;
  logic [4:0] b_cnt;
  logic c_clr = 0, c_iv = 0, c_ir, c_ov, c_or = 0, c_ovf;
  logic [7:0] c_prod = 0;
  logic [11:0] c_sum;
  logic [4:0] c_cnt;
  product_accumulator #(.N(4), .ACC_W(12)) dut_a (.clk(clk), .rst_n(rst_n), .clr(a_clr), .in_valid(a_iv),
    .in_ready(a_ir), .prod(a_prod), .out_valid(a_ov), .out_ready(a_or), .sum(a_sum), .ovf(a_ovf), .cnt(a_cnt));
  product_accumulator #(.N(2), .ACC_W(8)) dut_b (.clk(clk), .rst_n(rst_n), .clr(b_clr), .in_valid(b_iv),
    .in_ready(b_ir), .prod(b_prod), .out_valid(b_ov), .out_ready(b_or), .sum(b_sum), .ovf(b_ovf), .cnt(b_cnt));
  product_accumulator #(.N(1), .ACC_W(12)) dut_c (.clk(clk), .rst_n(rst_n), .clr(c_clr), .in_valid(c_iv),
    .in_ready(c_ir), .prod(c_prod), .out_valid(c_ov), .out_ready(c_or), .sum(c_sum), .ovf(c_ovf), .cnt(c_cnt));
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask
  task automatic a_feed(input logic [7:0] p);
    a_iv = 1'b1;
    a_prod = p;
    tick();
    a_iv = 1'b0;
  endtask
  task automatic b_feed(input logic [7:0] p);
    b_iv = 1'b1;
    b_prod = p;
    tick();
    b_iv = 1'b0;
  endtask
  initial begin
    tick();
    tick();
    rst_n = 1'b1;
    chk("rst_in_ready", a_ir, 1);
    chk("rst_out_valid", a_ov, 0);
    chk("rst_sum", a_sum, 0);
    chk("rst_ovf", a_ovf, 0);
    chk("rst_cnt", a_cnt, 0);
    a_feed(225);
    a_feed(1);
    a_feed(0);
    chk("basic_cnt3", a_cnt, 3);
    chk("basic_ov_early", a_ov, 0);
    a_feed(100);
    chk("basic_ov", a_ov, 1);
    chk("basic_sum", a_sum, 326);
    chk("basic_ovf", a_ovf, 0);
    chk("basic_cnt", a_cnt, 4);
    chk("basic_ir_out", a_ir, 0);
    a_or = 1'b1;
    tick();
    a_or = 1'b0;
    chk("basic_ir_after", a_ir, 1);
    chk("basic_cnt_after", a_cnt, 0);
    chk("basic_ov_after", a_ov, 0);
    a_feed(10);
    tick();
    a_feed(20);
    tick();
    tick();
    a_feed(30);
    tick();
    a_feed(40);
    for (int i = 0; i < 5; i++) begin
      chk("bp_ir", a_ir, 0);
      chk("bp_ov", a_ov, 1);
      chk("bp_sum", a_sum, 100);
      tick();
    end
    a_or = 1'b1;
    tick();
    a_or = 1'b0;
    chk("bp_ir_after", a_ir, 1);
    chk("bp_cnt_after", a_cnt, 0);
    a_feed(50);
    a_feed(60);
    chk("clr_cnt_pre", a_cnt, 2);
    a_iv = 1'b1;
    a_prod = 70;
    a_clr = 1'b1;
    #1;
    chk("clr_ir", a_ir, 0);
    tick();
    a_clr = 1'b0;
    a_iv = 1'b0;
    chk("clr_cnt", a_cnt, 0);
    a_feed(1);
    a_feed(2);
    a_feed(3);
    a_feed(4);
    chk("clr_ov", a_ov, 1);
    chk("clr_sum", a_sum, 10);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("rstout_ov", a_ov, 0);
    chk("rstout_sum", a_sum, 0);
    chk("rstout_ovf", a_ovf, 0);
    chk("rstout_cnt", a_cnt, 0);
    chk("rstout_ir", a_ir, 1);
    b_feed(200);
    b_feed(100);
    chk("b1_ov", b_ov, 1);
`ifdef ACC_SATURATE_EN
    chk("b1_sum", b_sum, 255);
`else
    chk("b1_sum", b_sum, 44);
`endif
    chk("b1_ovf", b_ovf, 1);
    b_or = 1'b1;
    tick();
    b_or = 1'b0;
`ifdef ACC_SATURATE_EN
    b_feed(255);
    b_feed(0);
    chk("b2_sum", b_sum, 255);
`else
    b_feed(3);
    b_feed(4);
    chk("b2_sum", b_sum, 7);
`endif
    chk("b2_ovf", b_ovf, 0);
    chk("b2_ov", b_ov, 1);
    c_or = 1'b1;
    c_iv = 1'b1;
    c_prod = 9;
    tick();
    c_prod = 15;
    chk("n1_ov1", c_ov, 1);
    chk("n1_sum1", c_sum, 9);
    chk("n1_ir1", c_ir, 0);
    chk("n1_cnt1", c_cnt, 1);
    tick();
    chk("n1_ir_gap", c_ir, 1);
    chk("n1_ov_gap", c_ov, 0);
    tick();
    c_iv = 1'b0;
    chk("n1_ov2", c_ov, 1);
    chk("n1_sum2", c_sum, 15);
    chk("n1_ir2", c_ir, 0);
    tick();
    chk("n1_ov_end", c_ov, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/product_accumulator.md
# product_accumulator

Sequential accumulation stage placed directly downstream of the 4x4 combinational array multiplier. It accepts one 8-bit product per valid/ready handshake and sums `N` consecutive products into a frame sum. It presents that sum on a valid/ready output port together with a sticky overflow flag. This forms the multiply-accumulate path for small dot products built from 4-bit operands.

## Interface
- `N`, default 8: products per frame; legal range 1..32.
- `ACC_W`, default 12: accumulator and sum width in bits; legal range 8..16.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst_n` input 1: reset, synchronous and active-low.
- `clr` input 1: synchronous frame abort; drops the partial sum.
- `in_valid` input 1: `prod` holds a valid product.
- `in_ready` output 1: block can accept `prod` this cycle.
- `prod` input 8: unsigned product taken from the multiplier result bus.
- `out_valid` output 1: `sum` and `ovf` hold a completed frame.
- `out_ready` input 1: consumer takes the frame this cycle.
- `sum` output ACC_W: frame sum, unsigned.
- `ovf` output 1: frame overflowed `ACC_W` bits.
- `cnt` output 5: number of products accepted in the current frame.

## Operation
- FSM states:
  - ACC: accepting products.
  - OUT: holding a completed result.
- Accept condition: `in_valid && in_ready`.
- In ACC:
  - `in_ready = !clr`.
  - On each accept, `acc <= acc + prod` (zero-extended) and `cnt <= cnt + 1`.
  - Carry out of bit `ACC_W-1` sets the sticky internal overflow bit.
  - The accept that brings `cnt` to `N` loads `sum` with the updated accumulator and loads `ovf` with the updated sticky bit. It then moves to OUT. `cnt` reads `N` while in OUT.
- In OUT:
  - `in_ready = 0` (no overlap between frames).
  - `out_valid = 1`.
  - `sum` and `ovf` are held stable until the handshake.
  - On `out_valid && out_ready`: clear `acc`, `cnt` and the sticky bit, then return to ACC.
- `clr` (when `rst_n = 1`), in either state:
  - Next state is ACC with `acc`, `cnt` and the sticky bit cleared.
  - `out_valid` drops, and any frame being held or handshaken that cycle is discarded.
  - No product is accepted in a `clr` cycle.
- Arithmetic: without the configuration macro, the sum wraps modulo 2^ACC_W. `ovf` reports that any wrap occurred during the frame.
- With `N = 1`, every accept completes a frame.

## Timing
- Reset values: state ACC, `in_ready` 1 (`clr` low), `out_valid` 0, `sum` 0, `ovf` 0, `cnt` 0.
- Reset has priority over `clr`; `clr` has priority over the handshakes.
- Latency: `out_valid` rises on the cycle after the Nth accept.
- Throughput: at least N+1 cycles per frame (N accepts plus 1 output handshake cycle). `in_ready` returns high on the cycle after the output handshake.
- Backpressure: while `out_ready` is low, `sum`, `ovf` and `out_valid` stay constant indefinitely.
- Reset asserted mid-frame or mid-OUT: all outputs take their reset values on the next edge, and the partial frame is lost.
- `prod` is sampled only on accept cycles; its value at other times is don't-care.
- `in_valid` may drop between products. Gaps do not affect the sum.

## Configuration
- `ACC_SATURATE_EN` defined: each accumulation clamps at 2^ACC_W−1 instead of wrapping. `ovf` is set whenever clamping occurs, and the accumulator stays at the maximum for the rest of the frame.
- `ACC_SATURATE_EN` undefined: modulo wrap as described under Operation; `ovf` semantics are unchanged.
- Ports and latency are identical in both builds.

## Test plan
- Basic frame (N=4, ACC_W=12): feed 225, 1, 0, 100 back-to-back. Required: `out_valid` high one cycle after the 4th accept, `sum`=326, `ovf`=0, `cnt`=4.
- Gapped input and backpressure (N=4): feed 10, 20, 30, 40 with idle cycles between, and hold `out_ready` low for 5 cycles. Required: `in_ready`=0 and `sum`=100 stable throughout; after the handshake cycle, `in_ready`=1 and `cnt`=0.
- Wrap (N=2, ACC_W=8, macro undefined): feed 200, 100. Required: `sum`=44, `ovf`=1. The next frame 3, 4 gives `sum`=7, `ovf`=0.
- Saturate (same parameters, `ACC_SATURATE_EN` defined): feed 200, 100, then a frame of 255, 0. Required: first `sum`=255 with `ovf`=1; second `sum`=255 with `ovf`=0.
- Clear and reset:
  - N=4: accept 50, 60, assert `clr` for 1 cycle while `in_valid`=1 with 70. Required: 70 not accepted and `cnt`=0; feeding 1, 2, 3, 4 then yields `sum`=10.
  - Repeat with `rst_n` low mid-OUT. Required: `out_valid`=0, `sum`=0, `ovf`=0 next cycle.
- N=1 (ACC_W=12): feed 9, 15 back-to-back with `out_ready` held high. Required: two frames, `sum`=9 then 15, each output one cycle after its accept, and `in_ready` low during each OUT cycle.
